// File: rtl/gba_vram_pkg.sv
// Shared VRAM geometry, word/address types and the line-fetch FSM state encoding.
package gba_vram_pkg;

  localparam int VRAM_ADDR_W = 14;
  localparam int VRAM_DATA_W = 32;

  typedef logic [VRAM_ADDR_W-1:0] vram_addr_t;
  typedef logic [VRAM_DATA_W-1:0] vram_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/vram_fetch_fifo.sv
// Small register-array FIFO with a registered head word, so the consumer sees
// a flop output that is stable while it stalls.
module vram_fetch_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  output logic [DATA_W-1:0]       head_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_next;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_next = rd_ptr + 1'b1;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_next;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Head reloads from the incoming word when the FIFO is (about to be) empty,
  // otherwise from the entry behind the one being popped.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
    if (empty || (count == CNT_W'(1) && pop_ok)) begin
      if (push_ok) head_data <= push_data;
    end else if (pop_ok) begin
      head_data <= mem[rd_next];
    end
  end

endmodule

// File: rtl/vram_line_fetch.sv
// Burst reader on the VRAM B port: walks sequential words from start_addr and
// buffers them for the line renderer behind a valid/ready interface.
module vram_line_fetch
  import gba_vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W,
  parameter int DEPTH  = 8,
  parameter int LEN_W  = 9
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       start_addr,
  input  logic [LEN_W-1:0]        word_count,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       vram_address_b,
  input  logic [DATA_W-1:0]       vram_q_b,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remain;
  logic              pop;
  logic              fire;
  logic              fifo_empty;
  logic              fifo_full;

  assign pop            = out_valid && out_ready;
  assign fire           = (state == FETCH) && !abort && (!fifo_full || pop);
  assign out_valid      = !fifo_empty;
  assign vram_address_b = addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      addr   <= '0;
      remain <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              addr   <= start_addr;
              remain <= word_count;
              state  <= FETCH;
              busy   <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (fire) begin
            addr   <= addr + 1'b1;
            remain <= remain - 1'b1;
            if (remain == LEN_W'(1)) begin
              done  <= 1'b1;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (fifo_empty || (fifo_level == CNT_W'(1) && pop)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  vram_fetch_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (abort),
    .push      (fire),
    .push_data (vram_q_b),
    .pop       (pop),
    .head_data (out_data),
    .count     (fifo_level),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_vram_line_fetch.sv
// Directed bench for vram_line_fetch with a VRAM model holding 0xA000_0000+k at word k.
module tb_vram_line_fetch;

  logic        clock;
  logic        reset;
  logic        start;
  logic [13:0] start_addr;
  logic [8:0]  word_count;
  logic        abort;
  logic        busy;
  logic        done;
  logic [13:0] vram_address_b;
  logic [31:0] vram_q_b;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  fifo_level;

  int pass_cnt  = 0;
  int total_cnt = 0;

  vram_line_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .start_addr     (start_addr),
    .word_count     (word_count),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .vram_address_b (vram_address_b),
    .vram_q_b       (vram_q_b),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .fifo_level     (fifo_level)
  );

  assign vram_q_b = 32'hA000_0000 | {18'd0, vram_address_b};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_word(input logic [13:0] a);
    return 32'hA000_0000 | {18'd0, a};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic start_burst(input logic [13:0] a, input logic [8:0] n);
    start_addr = a;
    word_count = n;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  // Pops words as they appear and compares them against the ascending address sequence.
  task automatic collect(input string tag, input logic [13:0] base, input int n);
    int got = 0;
    int dn  = 0;
    logic [13:0] a;
    for (int c = 0; c < 200 && got < n; c++) begin
      if (done) dn++;
      if (out_valid && out_ready) begin
        a = base + got[13:0];
        check({tag, "_data"}, out_data, exp_word(a));
        got++;
      end
      step();
    end
    check({tag, "_count"}, got, n);
    check({tag, "_done"}, dn, 1);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    out_ready  = 1'b0;
    start_addr = '0;
    word_count = '0;
    step();
    step();
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_addr",  vram_address_b, 0);
    check("rst_level", fifo_level, 0);
    reset = 1'b0;
    step();

    // Basic 4-word burst, consumer always ready
    out_ready = 1'b1;
    start_burst(14'h0010, 9'd4);
    check("t1_busy",  busy, 1);
    check("t1_valid_early", out_valid, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("t1_valid", out_valid, 1);
      check("t1_data",  out_data, 32'hA000_0010 + i);
      check("t1_done",  done, (i == 3) ? 1 : 0);
      step();
    end
    check("t1_busy_end",  busy, 0);
    check("t1_valid_end", out_valid, 0);
    check("t1_done_end",  done, 0);

    // Back-pressure: FIFO fills, address counter stalls
    out_ready = 1'b0;
    start_burst(14'h0010, 9'd20);
    for (int i = 0; i < 11; i++) step();
    check("bp_level", fifo_level, 8);
    check("bp_addr",  vram_address_b, 14'h0018);
    check("bp_busy",  busy, 1);
    check("bp_head",  out_data, 32'hA000_0010);
    out_ready = 1'b1;
    collect("bp", 14'h0010, 20);
    step();
    check("bp_busy_end",  busy, 0);
    check("bp_valid_end", out_valid, 0);

    // Address wrap-around at the top of VRAM
    start_burst(14'h3FFE, 9'd4);
    collect("wrap", 14'h3FFE, 4);
    check("wrap_addr", vram_address_b, 14'h0002);

    // Zero-length request
    start_burst(14'h0055, 9'd0);
    check("zl_done",  done, 1);
    check("zl_busy",  busy, 0);
    check("zl_valid", out_valid, 0);
    step();
    check("zl_done_off", done, 0);
    check("zl_level",    fifo_level, 0);

    // Start while busy is ignored
    start_burst(14'h0100, 9'd3);
    start_addr = 14'h0200;
    word_count = 9'd5;
    start      = 1'b1;
    step();
    start      = 1'b0;
    collect("ign", 14'h0100, 3);
    step();
    step();
    check("ign_busy",  busy, 0);
    check("ign_valid", out_valid, 0);
    check("ign_addr",  vram_address_b, 14'h0103);

    // Abort after 5 pushes, with a competing start
    out_ready = 1'b0;
    start_burst(14'h0040, 9'd16);
    for (int i = 0; i < 5; i++) step();
    check("ab_level_pre", fifo_level, 5);
    abort      = 1'b1;
    start      = 1'b1;
    start_addr = 14'h0080;
    word_count = 9'd4;
    step();
    abort = 1'b0;
    start = 1'b0;
    check("ab_busy",  busy, 0);
    check("ab_level", fifo_level, 0);
    check("ab_valid", out_valid, 0);
    check("ab_done",  done, 0);
    step();
    step();
    check("ab_busy_later",  busy, 0);
    check("ab_level_later", fifo_level, 0);
    out_ready = 1'b1;
    start_burst(14'h0020, 9'd2);
    collect("ab_fresh", 14'h0020, 2);

    // Reset during FETCH with three words buffered
    out_ready = 1'b0;
    start_burst(14'h0300, 9'd10);
    for (int i = 0; i < 3; i++) step();
    check("mr_level_pre", fifo_level, 3);
    reset     = 1'b1;
    out_ready = 1'b1;
    step();
    check("mr_busy",  busy, 0);
    check("mr_done",  done, 0);
    check("mr_valid", out_valid, 0);
    check("mr_addr",  vram_address_b, 0);
    check("mr_level", fifo_level, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("mr_valid_after", out_valid, 0);
    check("mr_level_after", fifo_level, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
